// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Register offsets and field indices shared by the PWM
//                controller top level and its channel instances.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Global register offsets (byte addresses, word aligned)
    localparam logic [7:0] C_OFF_CTRL     = 8'h00;
    localparam logic [7:0] C_OFF_CH_EN    = 8'h04;
    localparam logic [7:0] C_OFF_INT_STAT = 8'h08;
    localparam logic [7:0] C_OFF_INT_EN   = 8'h0C;

    // Channel window: channel c lives at C_OFF_CH_BASE + C_CH_STRIDE*c
    localparam logic [7:0] C_OFF_CH_BASE  = 8'h10;
    localparam logic [7:0] C_CH_STRIDE    = 8'h10;

    // Offsets inside one channel window
    localparam logic [3:0] C_CH_PERIOD    = 4'h0;
    localparam logic [3:0] C_CH_DUTY      = 4'h4;
    localparam logic [3:0] C_CH_CFG       = 4'h8;
    localparam logic [3:0] C_CH_COUNT     = 4'hC;

    // CFG register bits
    localparam int C_CFG_POL    = 0;
    localparam int C_CFG_CENTER = 1;

    // CTRL register fields
    localparam int C_CTRL_GEN       = 0;
    localparam int C_CTRL_PRESC_LSB = 8;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_channel
//  Description : One PWM channel: edge/center counter, shadowed period and
//                duty compare, polarity, registered output and wrap pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,       // GEN & CH_EN[c]
    input  logic             i_tick,     // shared prescaler tick
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_duty,
    input  logic             i_pol,
    input  logic             i_center,
    output logic             o_pwm,
    output logic             o_wrap,     // one-cycle pulse at period boundary
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt_q,     w_cnt_d;
    logic             r_down_q,    w_down_d;
    logic [CNT_W-1:0] r_per_sh_q,  w_per_sh_d;
    logic [CNT_W-1:0] r_duty_sh_q, w_duty_sh_d;
    logic             r_pwm_q,     w_pwm_d;
    logic             w_wrap;
    logic             w_raw;

    // Counter, direction and shadow update; shadows only move at a wrap
    always_comb begin
        w_cnt_d     = r_cnt_q;
        w_down_d    = r_down_q;
        w_per_sh_d  = r_per_sh_q;
        w_duty_sh_d = r_duty_sh_q;
        w_wrap      = 1'b0;
        if (!i_en) begin
            // Idle: park at zero counting up, shadows follow the registers
            w_cnt_d     = '0;
            w_down_d    = 1'b0;
            w_per_sh_d  = i_period;
            w_duty_sh_d = i_duty;
        end else if (i_tick) begin
            if (!i_center) begin
                w_down_d = 1'b0;
                if (r_cnt_q >= r_per_sh_q) begin
                    w_cnt_d = '0;
                    w_wrap  = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end else if (r_per_sh_q == '0) begin
                // Degenerate center period: every tick closes a period
                w_cnt_d  = '0;
                w_down_d = 1'b0;
                w_wrap   = 1'b1;
            end else if (!r_down_q) begin
                if (r_cnt_q >= r_per_sh_q) begin
                    // Top endpoint held for one tick, then start down
                    w_cnt_d = r_per_sh_q - CNT_W'(1);
                    if (r_per_sh_q == CNT_W'(1)) begin
                        w_wrap   = 1'b1;
                        w_down_d = 1'b0;
                    end else begin
                        w_down_d = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end else begin
                if (r_cnt_q <= CNT_W'(1)) begin
                    // Down count reaches zero: period boundary
                    w_cnt_d  = '0;
                    w_down_d = 1'b0;
                    w_wrap   = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q - CNT_W'(1);
                end
            end
            if (w_wrap) begin
                w_per_sh_d  = i_period;
                w_duty_sh_d = i_duty;
            end
        end
    end

    // Compare against the shadow duty; disabled channel rests at POL
    always_comb begin
        w_raw   = (r_cnt_q < r_duty_sh_q);
        w_pwm_d = i_en ? (w_raw ^ i_pol) : i_pol;
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q     <= '0;
            r_down_q    <= 1'b0;
            r_per_sh_q  <= '0;
            r_duty_sh_q <= '0;
            r_pwm_q     <= 1'b0;
        end else begin
            r_cnt_q     <= w_cnt_d;
            r_down_q    <= w_down_d;
            r_per_sh_q  <= w_per_sh_d;
            r_duty_sh_q <= w_duty_sh_d;
            r_pwm_q     <= w_pwm_d;
        end
    end

    assign o_pwm  = r_pwm_q;
    assign o_wrap = w_wrap;
    assign o_cnt  = r_cnt_q;

endmodule : pwm_channel
`default_nettype wire

// File: rtl/pwm_multi_apb.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi_apb
//  Description : Multi-channel PWM controller with APB register access,
//                shared prescaler and per-channel W1C wrap interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_apb
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PRE_W  = 8
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [31:0]       apb_addr,
    input  logic              apb_sel,
    input  logic              apb_write,
    input  logic              apb_ena,
    input  logic [31:0]       apb_wdata,
    output logic [31:0]       apb_rdata,
    input  logic [3:0]        apb_pstb,
    output logic              apb_rready,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              irq
);

    logic                          r_gen_q,      w_gen_d;
    logic [PRE_W-1:0]              r_presc_q,    w_presc_d;
    logic [PRE_W-1:0]              r_pre_cnt_q,  w_pre_cnt_d;
    logic [NUM_CH-1:0]             r_ch_en_q,    w_ch_en_d;
    logic [NUM_CH-1:0]             r_int_stat_q, w_int_stat_d;
    logic [NUM_CH-1:0]             r_int_en_q,   w_int_en_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  r_period_q,   w_period_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  r_duty_q,     w_duty_d;
    logic [NUM_CH-1:0]             r_pol_q,      w_pol_d;
    logic [NUM_CH-1:0]             r_center_q,   w_center_d;
    logic [31:0]                   r_rdata_q,    w_rdata_d;

    logic                          w_wr;
    logic                          w_rd;
    logic [7:0]                    w_addr;
    logic                          w_tick;
    logic [NUM_CH-1:0]             w_int_clr;
    logic [NUM_CH-1:0]             w_wrap;
    logic [NUM_CH-1:0][CNT_W-1:0]  w_cnt;
    logic                          w_unused_bits;

    assign w_addr = apb_addr[7:0];
    assign w_wr   = apb_sel &  apb_write & ~apb_ena;
    assign w_rd   = apb_sel & ~apb_write & ~apb_ena;

    // Upper address bits and byte strobes carry no meaning here
    assign w_unused_bits = ^{apb_addr[31:8], apb_pstb, apb_wdata};

    // Prescaler: count 0..PRESC while enabled, tick on the terminal value
    always_comb begin
        w_tick      = r_gen_q && (r_pre_cnt_q == r_presc_q);
        w_pre_cnt_d = (!r_gen_q || (r_pre_cnt_q >= r_presc_q)) ? '0
                                                               : r_pre_cnt_q + PRE_W'(1);
    end

    // Register write decode; a wrap on the same cycle as a W1C keeps the bit
    always_comb begin
        w_gen_d    = r_gen_q;
        w_presc_d  = r_presc_q;
        w_ch_en_d  = r_ch_en_q;
        w_int_en_d = r_int_en_q;
        w_period_d = r_period_q;
        w_duty_d   = r_duty_q;
        w_pol_d    = r_pol_q;
        w_center_d = r_center_q;
        w_int_clr  = '0;
        if (w_wr) begin
            case (w_addr)
                C_OFF_CTRL: begin
                    w_gen_d   = apb_wdata[C_CTRL_GEN];
                    w_presc_d = apb_wdata[C_CTRL_PRESC_LSB +: PRE_W];
                end
                C_OFF_CH_EN:    w_ch_en_d  = apb_wdata[NUM_CH-1:0];
                C_OFF_INT_STAT: w_int_clr  = apb_wdata[NUM_CH-1:0];
                C_OFF_INT_EN:   w_int_en_d = apb_wdata[NUM_CH-1:0];
                default: ;
            endcase
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_addr[7:4] == 4'(c + 1)) begin
                    case (w_addr[3:0])
                        C_CH_PERIOD: w_period_d[c] = apb_wdata[CNT_W-1:0];
                        C_CH_DUTY:   w_duty_d[c]   = apb_wdata[CNT_W-1:0];
                        C_CH_CFG: begin
                            w_pol_d[c]    = apb_wdata[C_CFG_POL];
                            w_center_d[c] = apb_wdata[C_CFG_CENTER];
                        end
                        default: ;
                    endcase
                end
            end
        end
        w_int_stat_d = (r_int_stat_q & ~w_int_clr) | w_wrap;
    end

    // Read mux, captured in the setup phase and held otherwise
    always_comb begin
        w_rdata_d = r_rdata_q;
        if (w_rd) begin
            w_rdata_d = '0;
            case (w_addr)
                C_OFF_CTRL: begin
                    w_rdata_d[C_CTRL_GEN]                 = r_gen_q;
                    w_rdata_d[C_CTRL_PRESC_LSB +: PRE_W]  = r_presc_q;
                end
                C_OFF_CH_EN:    w_rdata_d[NUM_CH-1:0] = r_ch_en_q;
                C_OFF_INT_STAT: w_rdata_d[NUM_CH-1:0] = r_int_stat_q;
                C_OFF_INT_EN:   w_rdata_d[NUM_CH-1:0] = r_int_en_q;
                default: ;
            endcase
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_addr[7:4] == 4'(c + 1)) begin
                    case (w_addr[3:0])
                        C_CH_PERIOD: w_rdata_d[CNT_W-1:0] = r_period_q[c];
                        C_CH_DUTY:   w_rdata_d[CNT_W-1:0] = r_duty_q[c];
                        C_CH_CFG: begin
                            w_rdata_d[C_CFG_POL]    = r_pol_q[c];
                            w_rdata_d[C_CFG_CENTER] = r_center_q[c];
                        end
                        C_CH_COUNT:  w_rdata_d[CNT_W-1:0] = w_cnt[c];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Register file, prescaler and read-data registers
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_gen_q      <= 1'b0;
            r_presc_q    <= '0;
            r_pre_cnt_q  <= '0;
            r_ch_en_q    <= '0;
            r_int_stat_q <= '0;
            r_int_en_q   <= '0;
            r_period_q   <= '0;
            r_duty_q     <= '0;
            r_pol_q      <= '0;
            r_center_q   <= '0;
            r_rdata_q    <= '0;
        end else begin
            r_gen_q      <= w_gen_d;
            r_presc_q    <= w_presc_d;
            r_pre_cnt_q  <= w_pre_cnt_d;
            r_ch_en_q    <= w_ch_en_d;
            r_int_stat_q <= w_int_stat_d;
            r_int_en_q   <= w_int_en_d;
            r_period_q   <= w_period_d;
            r_duty_q     <= w_duty_d;
            r_pol_q      <= w_pol_d;
            r_center_q   <= w_center_d;
            r_rdata_q    <= w_rdata_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clock),
            .rst      (rst),
            .i_en     (r_gen_q & r_ch_en_q[c]),
            .i_tick   (w_tick),
            .i_period (r_period_q[c]),
            .i_duty   (r_duty_q[c]),
            .i_pol    (r_pol_q[c]),
            .i_center (r_center_q[c]),
            .o_pwm    (pwm_o[c]),
            .o_wrap   (w_wrap[c]),
            .o_cnt    (w_cnt[c])
        );
    end

    assign apb_rdata  = r_rdata_q;
    assign apb_rready = 1'b1;
    assign irq        = |(r_int_stat_q & r_int_en_q);

endmodule : pwm_multi_apb
`default_nettype wire

// File: tb/tb_pwm_multi_apb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_multi_apb
//  Description : Directed self-checking bench for pwm_multi_apb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_apb;

    logic        clock;
    logic        rst;
    logic [31:0] apb_addr;
    logic        apb_sel;
    logic        apb_write;
    logic        apb_ena;
    logic [31:0] apb_wdata;
    logic [31:0] apb_rdata;
    logic [3:0]  apb_pstb;
    logic        apb_rready;
    logic [3:0]  pwm_o;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_multi_apb #(
        .NUM_CH (4),
        .CNT_W  (16),
        .PRE_W  (8)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .apb_addr   (apb_addr),
        .apb_sel    (apb_sel),
        .apb_write  (apb_write),
        .apb_ena    (apb_ena),
        .apb_wdata  (apb_wdata),
        .apb_rdata  (apb_rdata),
        .apb_pstb   (apb_pstb),
        .apb_rready (apb_rready),
        .pwm_o      (pwm_o),
        .irq        (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Write: register updates on the setup-phase edge
    task automatic apb_wr(input logic [7:0] addr, input logic [31:0] data);
        apb_addr  = {24'h0, addr};
        apb_wdata = data;
        apb_sel   = 1'b1;
        apb_write = 1'b1;
        apb_ena   = 1'b0;
        adv(1);
        apb_ena   = 1'b1;
        adv(1);
        apb_sel   = 1'b0;
        apb_ena   = 1'b0;
        apb_write = 1'b0;
    endtask

    // Read: data sampled during the access phase
    task automatic apb_rd(input logic [7:0] addr, output logic [31:0] data);
        apb_addr  = {24'h0, addr};
        apb_sel   = 1'b1;
        apb_write = 1'b0;
        apb_ena   = 1'b0;
        adv(1);
        data      = apb_rdata;
        apb_ena   = 1'b1;
        adv(1);
        apb_sel   = 1'b0;
        apb_ena   = 1'b0;
    endtask

    // Sample one output per clock into a bit vector, LSB first
    task automatic capture(input int ch, input int n, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[i] = pwm_o[ch];
            adv(1);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] v;
        logic [7:0]  zaddr [7];

        rst = 1'b1; apb_addr = '0; apb_sel = 1'b0; apb_write = 1'b0;
        apb_ena = 1'b0; apb_wdata = '0; apb_pstb = 4'hF;
        adv(2);
        rst = 1'b0;

        // Reset state
        check("reset_pwm",    {28'h0, pwm_o}, 32'h0);
        check("reset_irq",    {31'h0, irq},   32'h0);
        check("reset_rdata",  apb_rdata,      32'h0);
        check("reset_rready", {31'h0, apb_rready}, 32'h1);

        // Edge mode, PERIOD=9 DUTY=3: 3 high / 7 low per 10 clocks
        apb_wr(8'h10, 32'd9);
        apb_wr(8'h14, 32'd3);
        apb_wr(8'h00, 32'h1);
        apb_wr(8'h04, 32'h1);
        capture(0, 20, v);
        check("edge_d3_wave", v, 32'h0000_1C07);

        // DUTY=7 written mid-period: current period keeps 3-high
        apb_wr(8'h14, 32'd7);
        capture(0, 20, v);
        check("edge_midwrite_wave", v, 32'h000C_7F01);
        apb_rd(8'h08, rd);
        check("int_stat_ch0", rd, 32'h1);

        // Center mode ch1, PERIOD=4 DUTY=2, PRESC=1
        apb_wr(8'h04, 32'h0);
        apb_wr(8'h28, 32'h2);
        apb_wr(8'h20, 32'd4);
        apb_wr(8'h24, 32'd2);
        apb_wr(8'h00, 32'h101);
        apb_wr(8'h04, 32'h2);
        capture(1, 20, v);
        check("center_wave", v, 32'h000F_C00F);
        apb_rd(8'h2C, rd);
        check("center_count", rd, 32'd2);

        // Polarity and duty extremes on ch0
        apb_wr(8'h00, 32'h0);
        apb_wr(8'h04, 32'h0);
        apb_wr(8'h18, 32'h1);
        apb_wr(8'h14, 32'd0);
        apb_wr(8'h10, 32'd9);
        apb_wr(8'h00, 32'h1);
        apb_wr(8'h04, 32'h1);
        adv(3);
        capture(0, 12, v);
        check("pol_duty0_const1", v, 32'h0000_0FFF);
        apb_wr(8'h14, 32'd10);
        adv(12);
        capture(0, 12, v);
        check("pol_duty_over_const0", v, 32'h0);
        apb_wr(8'h04, 32'h0);
        check("pol_disabled_idle", {28'h0, pwm_o}, 32'h1);

        // Interrupts: W1C coincident with a wrap keeps the bit
        apb_wr(8'h18, 32'h0);
        apb_wr(8'h14, 32'd3);
        apb_wr(8'h08, 32'hF);
        apb_rd(8'h08, rd);
        check("int_stat_cleared", rd, 32'h0);
        apb_wr(8'h0C, 32'h1);
        check("irq_idle", {31'h0, irq}, 32'h0);
        apb_wr(8'h04, 32'h1);
        adv(8);
        check("irq_before_wrap", {31'h0, irq}, 32'h0);
        adv(1);
        check("irq_after_wrap", {31'h0, irq}, 32'h1);
        adv(9);
        apb_wr(8'h08, 32'h1);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        apb_rd(8'h08, rd);
        check("int_stat_set_wins", rd, 32'h1);
        apb_wr(8'h08, 32'h1);
        check("irq_w1c", {31'h0, irq}, 32'h0);

        // Live count and register map
        apb_rd(8'h1C, rd);
        check("count_ch0_live", rd, 32'd5);
        apb_rd(8'hFC, rd);
        check("unmapped_fc", rd, 32'h0);
        apb_wr(8'h80, 32'hFFFF_FFFF);
        apb_rd(8'h80, rd);
        check("unmapped_80", rd, 32'h0);
        apb_rd(8'h00, rd);
        check("ctrl_read", rd, 32'h1);
        apb_rd(8'h20, rd);
        check("period1_read", rd, 32'd4);
        apb_rd(8'h28, rd);
        check("cfg1_read", rd, 32'h2);
        apb_wr(8'h0C, 32'hFFFF_FFFF);
        apb_rd(8'h0C, rd);
        check("int_en_unused_bits", rd, 32'hF);

        // Asynchronous reset while output is high under POL=1
        apb_wr(8'h18, 32'h1);
        apb_wr(8'h14, 32'd0);
        adv(14);
        check("pre_reset_pwm", {31'h0, pwm_o[0]}, 32'h1);
        check("pre_reset_irq", {31'h0, irq}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_pwm",   {28'h0, pwm_o}, 32'h0);
        check("async_reset_irq",   {31'h0, irq},   32'h0);
        check("async_reset_rdata", apb_rdata,      32'h0);
        @(posedge clock);
        #1;
        rst = 1'b0;
        zaddr = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
        for (int i = 0; i < 7; i++) begin
            apb_rd(zaddr[i], rd);
            check($sformatf("post_reset_reg_%02h", zaddr[i]), rd, 32'h0);
        end
        apb_rd(8'h1C, rd);
        check("post_reset_count", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pwm_multi_apb
`default_nettype wire
